// File: rtl/vga_pattern_gen_if.sv
// Pixel-stage bus: coordinates/blanking/button in from the timing stage, RGB and status out.
// No handshake: every signal is sampled or presented each pixel clock.
interface vga_pattern_gen_if;
  logic [11:0] i_x;
  logic [11:0] i_y;
  logic        i_hblank;
  logic        i_vblank;
  logic        i_next;
  logic        o_red;
  logic        o_grn;
  logic        o_blu;
  logic [1:0]  o_mode;
  logic        o_frame_start;

  modport master (
    output i_x, i_y, i_hblank, i_vblank, i_next,
    input  o_red, o_grn, o_blu, o_mode, o_frame_start
  );

  modport slave (
    input  i_x, i_y, i_hblank, i_vblank, i_next,
    output o_red, o_grn, o_blu, o_mode, o_frame_start
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern colour stage: bars, checker, bouncing box, border; mode/box commit at frame start.
// Latency: RGB registered one pixel clock after its coordinates; no backpressure (free-running).
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BOX_SIZE   = 32,
  parameter int SPEED      = 2,
  parameter int CHECK_LOG2 = 5
) (
  input logic              i_clk,
  input logic              i_rst_n,
  vga_pattern_gen_if.slave bus
);

  localparam int          BAR_W  = H_ACTIVE / 8;
  localparam logic [11:0] SPD    = 12'(SPEED);
  localparam logic [11:0] BOX    = 12'(BOX_SIZE);
  localparam logic [11:0] X_LIM  = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] Y_LIM  = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);

  logic        vblank_q;
  logic [2:0]  sync_q;
  logic        pending_q, pending_d;
  logic [1:0]  mode_q, mode_d;
  logic [11:0] bx_q, bx_d, by_q, by_d;
  logic        dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        fs_q;

  logic        fb;
  logic        next_rise;
  logic        active;
  logic        in_box;
  logic        border;
  logic [2:0]  bar;
  logic [2:0]  pix;
  logic [12:0] x_step, y_step;

  // Result is {new direction (1 = decreasing), new position}; lim is the largest legal position.
  function automatic logic [12:0] step_axis(input logic [11:0] pos, input logic neg,
                                            input logic [11:0] lim);
    logic [12:0] r;
    if (!neg) begin
      if ({1'b0, pos} + {1'b0, SPD} >= {1'b0, lim}) r = {1'b1, lim};
      else                                          r = {1'b0, pos + SPD};
    end else begin
      if (pos <= SPD) r = {1'b0, 12'd0};
      else            r = {1'b1, pos - SPD};
    end
    return r;
  endfunction

  always_comb begin
    fb        = bus.i_vblank & ~vblank_q;
    next_rise = sync_q[1] & ~sync_q[2];
    x_step    = step_axis(bx_q, dx_neg_q, X_LIM);
    y_step    = step_axis(by_q, dy_neg_q, Y_LIM);

    pending_d = pending_q;
    mode_d    = mode_q;
    bx_d      = bx_q;
    by_d      = by_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;

    // A press whose synchronized edge lands on the boundary cycle still counts for this boundary.
    if (fb) begin
      if (pending_q | next_rise) begin
        mode_d    = mode_q + 2'd1;
        pending_d = 1'b0;
      end
      {dx_neg_d, bx_d} = x_step;
      {dy_neg_d, by_d} = y_step;
    end else if (next_rise) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    active = ~bus.i_hblank & ~bus.i_vblank & (bus.i_x < H_ACT) & (bus.i_y < V_ACT);

    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (bus.i_x >= 12'(k * BAR_W)) bar = bar + 3'd1;
    end

    in_box = (bus.i_x >= bx_q) && ({1'b0, bus.i_x} < ({1'b0, bx_q} + {1'b0, BOX})) &&
             (bus.i_y >= by_q) && ({1'b0, bus.i_y} < ({1'b0, by_q} + {1'b0, BOX}));
    border = (bus.i_x == 12'd0) || (bus.i_x == X_LAST) ||
             (bus.i_y == 12'd0) || (bus.i_y == Y_LAST);

    case (mode_q)
      2'd0:    pix = 3'd7 - bar;
      2'd1:    pix = (bus.i_x[CHECK_LOG2] ^ bus.i_y[CHECK_LOG2]) ? 3'b111 : 3'b000;
      2'd2:    pix = in_box ? 3'b100 : 3'b001;
      default: pix = border ? 3'b111 : 3'b010;
    endcase

    rgb_d = active ? pix : 3'b000;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vblank_q  <= 1'b0;
      sync_q    <= 3'b000;
      pending_q <= 1'b0;
      mode_q    <= 2'd0;
      bx_q      <= 12'd0;
      by_q      <= 12'd0;
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b0;
      rgb_q     <= 3'b000;
      fs_q      <= 1'b0;
    end else begin
      vblank_q  <= bus.i_vblank;
      sync_q    <= {sync_q[1:0], bus.i_next};
      pending_q <= pending_d;
      mode_q    <= mode_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_neg_q  <= dx_neg_d;
      dy_neg_q  <= dy_neg_d;
      rgb_q     <= rgb_d;
      fs_q      <= fb;
    end
  end

  assign bus.o_red         = rgb_q[2];
  assign bus.o_grn         = rgb_q[1];
  assign bus.o_blu         = rgb_q[0];
  assign bus.o_mode        = mode_q;
  assign bus.o_frame_start = fs_q;

endmodule
